// File: rtl/reg_file_sweep.sv
// Register file with two combinational read ports, one byte-masked write port,
// optional hardwired zero entry, optional write->read bypass and a sequential clear sweep.
module reg_file_sweep #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   readReg1,
    input  logic [ADDR_W-1:0]   readReg2,
    output logic [DATA_W-1:0]   readData1,
    output logic [DATA_W-1:0]   readData2,
    input  logic [ADDR_W-1:0]   writeReg,
    input  logic [DATA_W-1:0]   writeData,
    input  logic                regWrite,
    input  logic [DATA_W/8-1:0] byteEn,
    input  logic                clear,
    output logic                busy,
    output logic                clearDone,
    input  logic [ADDR_W-1:0]   displayReg,
    output logic [DATA_W-1:0]   displayData
);
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int BE_W     = DATA_W / 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SWEEP = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    function automatic logic [DATA_W-1:0] expand_mask(input logic [BE_W-1:0] be);
        logic [DATA_W-1:0] m;
        for (int b = 0; b < BE_W; b++) begin
            m[8*b +: 8] = {8{be[b]}};
        end
        return m;
    endfunction

    function automatic logic [DATA_W-1:0] read_mux(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              wr_hit,
        input logic [DATA_W-1:0] merged
    );
        if ((BYPASS != 0) && wr_hit) begin
            return merged;
        end else if ((ZERO_REG != 0) && (addr == {ADDR_W{1'b0}})) begin
            return {DATA_W{1'b0}};
        end else begin
            return stored;
        end
    endfunction

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              wr_en_s;
    logic [DATA_W-1:0] wr_mask_s;
    logic [DATA_W-1:0] wr_merged_s;

    // Write qualification and byte-merged write value (also the bypass value).
    always_comb begin
        wr_en_s     = regWrite && (state_q != ST_SWEEP) &&
                      !((ZERO_REG != 0) && (writeReg == {ADDR_W{1'b0}}));
        wr_mask_s   = expand_mask(byteEn);
        wr_merged_s = (regs_q[writeReg] & ~wr_mask_s) | (writeData & wr_mask_s);
    end

    // Sweep FSM; busy/clearDone are decoded from the next state so they leave flops.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clear) begin
                    state_d = ST_SWEEP;
                    cnt_d   = {ADDR_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SWEEP: begin
                if (cnt_q == {ADDR_W{1'b1}}) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {ADDR_W{1'b0}};
            end
        endcase
        busy_d = (state_d == ST_SWEEP);
        done_d = (state_d == ST_DONE);
    end

    // Next contents of the file: sweep clear has priority (writes are blocked then anyway).
    always_comb begin
        regs_d = regs_q;
        if (state_q == ST_SWEEP) begin
            regs_d[cnt_q] = {DATA_W{1'b0}};
        end else if (wr_en_s) begin
            regs_d[writeReg] = wr_merged_s;
        end else begin
            regs_d = regs_q;
        end
    end

    // State and storage registers; reset clears the whole file at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= {ADDR_W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign readData1   = read_mux(readReg1, regs_q[readReg1], wr_en_s && (writeReg == readReg1), wr_merged_s);
    assign readData2   = read_mux(readReg2, regs_q[readReg2], wr_en_s && (writeReg == readReg2), wr_merged_s);
    assign displayData = read_mux(displayReg, regs_q[displayReg], 1'b0, wr_merged_s);
    assign busy        = busy_q;
    assign clearDone   = done_q;
endmodule

// File: tb/tb_reg_file_sweep.sv
// Randomized self-checking bench: one DUT with ZERO_REG=1/BYPASS=1 (a) and one with 0/0 (b),
// both driven identically and compared against array models.
module tb_reg_file_sweep;
    logic        clk, reset, regWrite, clear;
    logic [4:0]  readReg1, readReg2, writeReg, displayReg;
    logic [31:0] writeData;
    logic [3:0]  byteEn;
    logic [31:0] rd1_a, rd2_a, disp_a, rd1_b, rd2_b, disp_b;
    logic        busy_a, done_a, busy_b, done_b;

    logic [31:0] m_a [32];
    logic [31:0] m_b [32];
    int tests = 0;
    int fails = 0;

    reg_file_sweep #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u_a (
        .clk(clk), .reset(reset), .readReg1(readReg1), .readReg2(readReg2),
        .readData1(rd1_a), .readData2(rd2_a), .writeReg(writeReg), .writeData(writeData),
        .regWrite(regWrite), .byteEn(byteEn), .clear(clear), .busy(busy_a),
        .clearDone(done_a), .displayReg(displayReg), .displayData(disp_a));

    reg_file_sweep #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) u_b (
        .clk(clk), .reset(reset), .readReg1(readReg1), .readReg2(readReg2),
        .readData1(rd1_b), .readData2(rd2_b), .writeReg(writeReg), .writeData(writeData),
        .regWrite(regWrite), .byteEn(byteEn), .clear(clear), .busy(busy_b),
        .clearDone(done_b), .displayReg(displayReg), .displayData(disp_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic zero_models;
        for (int i = 0; i < 32; i++) begin
            m_a[i] = 32'd0;
            m_b[i] = 32'd0;
        end
    endtask

    // Stimulus only: one write cycle while idle, models updated to the expected contents.
    task automatic drive_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        regWrite = 1'b1; writeReg = a; writeData = d; byteEn = be;
        tick;
        regWrite = 1'b0;
        if (a != 5'd0) m_a[a] = merge(m_a[a], d, be);
        m_b[a] = merge(m_b[a], d, be);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick; tick;
        tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL reset_busy got %0b want 0", busy_a); end
        tests++; if (done_a !== 1'b0) begin fails++; $display("FAIL reset_done got %0b want 0", done_a); end
        for (int i = 0; i < 32; i++) begin
            readReg1 = 5'(i); displayReg = 5'(i); #1;
            tests++; if (rd1_a !== 32'd0 || disp_a !== 32'd0 || rd1_b !== 32'd0) begin
                fails++; $display("FAIL reset_entry r%0d got %h/%h/%h want 0", i, rd1_a, disp_a, rd1_b); end
        end
        #2 reset = 1'b0;
        tick;
        zero_models();
    endtask

    task automatic test_byte_enable;
        logic [4:0] a;
        drive_write(5'd3, 32'hDEADBEEF, 4'hF);
        drive_write(5'd3, 32'h00001200, 4'b0010);
        readReg1 = 5'd3; #1;
        tests++; if (rd1_a !== 32'hDEAD12EF) begin fails++; $display("FAIL byte_en_r3 got %h want dead12ef", rd1_a); end
        for (int k = 0; k < 60; k++) begin
            drive_write(5'($urandom_range(31, 0)), $urandom, 4'($urandom_range(15, 0)));
        end
        for (int i = 0; i < 32; i++) begin
            a = 5'(i); readReg1 = a; readReg2 = 5'(31 - i); displayReg = a; #1;
            tests++; if (rd1_a !== m_a[a] || disp_a !== m_a[a] || rd2_a !== m_a[31-i]) begin
                fails++; $display("FAIL rand_read_a r%0d got %h/%h want %h", i, rd1_a, disp_a, m_a[a]); end
            tests++; if (rd1_b !== m_b[a] || rd2_b !== m_b[31-i]) begin
                fails++; $display("FAIL rand_read_b r%0d got %h want %h", i, rd1_b, m_b[a]); end
        end
    endtask

    task automatic test_zero_reg;
        drive_write(5'd0, 32'h00001234, 4'hF);
        readReg1 = 5'd0; #1;
        tests++; if (rd1_a !== 32'd0) begin fails++; $display("FAIL zero_reg_on got %h want 0", rd1_a); end
        tests++; if (rd1_b !== 32'h00001234) begin fails++; $display("FAIL zero_reg_off got %h want 1234", rd1_b); end
    endtask

    task automatic test_bypass;
        logic [4:0] a, r2;
        logic [31:0] d, exp1;
        logic [3:0] be;
        drive_write(5'd5, 32'd7, 4'hF);
        regWrite = 1'b1; writeReg = 5'd5; writeData = 32'd9; byteEn = 4'hF;
        readReg1 = 5'd5; readReg2 = 5'd5; displayReg = 5'd5; #1;
        tests++; if (rd1_a !== 32'd9 || rd2_a !== 32'd9) begin fails++; $display("FAIL bypass_on got %h/%h want 9", rd1_a, rd2_a); end
        tests++; if (disp_a !== 32'd7) begin fails++; $display("FAIL bypass_display got %h want 7", disp_a); end
        tests++; if (rd1_b !== 32'd7 || rd2_b !== 32'd7) begin fails++; $display("FAIL bypass_off got %h/%h want 7", rd1_b, rd2_b); end
        tick; regWrite = 1'b0;
        m_a[5] = 32'd9; m_b[5] = 32'd9;
        for (int k = 0; k < 12; k++) begin
            a = 5'($urandom_range(31, 0)); r2 = (k % 2 == 0) ? a : 5'($urandom_range(31, 0));
            d = $urandom; be = 4'($urandom_range(15, 0));
            regWrite = 1'b1; writeReg = a; writeData = d; byteEn = be; readReg1 = a; readReg2 = r2; #1;
            exp1 = (a == 5'd0) ? 32'd0 : merge(m_a[a], d, be);
            tests++; if (rd1_a !== exp1 || rd2_a !== ((r2 == a) ? exp1 : m_a[r2])) begin
                fails++; $display("FAIL bypass_rand_a r%0d got %h/%h want %h", a, rd1_a, rd2_a, exp1); end
            tests++; if (rd1_b !== m_b[a]) begin fails++; $display("FAIL bypass_rand_b r%0d got %h want %h", a, rd1_b, m_b[a]); end
            tick; regWrite = 1'b0;
            if (a != 5'd0) m_a[a] = exp1;
            m_b[a] = merge(m_b[a], d, be);
        end
    endtask

    task automatic test_sweep;
        int cnt;
        for (int i = 1; i < 32; i++) drive_write(5'(i), 32'(i), 4'hF);
        clear = 1'b1; tick; clear = 1'b0;
        cnt = 0;
        while (busy_a === 1'b1 && cnt < 40) begin
            readReg1 = 5'(cnt); readReg2 = (cnt == 3) ? 5'd7 : 5'(cnt - 1);
            regWrite = (cnt == 3); writeReg = 5'd7; writeData = 32'hFF; byteEn = 4'hF; #1;
            tests++; if (rd1_a !== m_a[cnt] || rd1_b !== m_b[cnt]) begin
                fails++; $display("FAIL sweep_unswept r%0d got %h/%h want %h/%h", cnt, rd1_a, rd1_b, m_a[cnt], m_b[cnt]); end
            if (cnt == 3) begin
                tests++; if (rd2_a !== 32'd7) begin fails++; $display("FAIL sweep_no_bypass got %h want 7", rd2_a); end
            end else if (cnt > 0) begin
                tests++; if (rd2_a !== 32'd0 || rd2_b !== 32'd0) begin
                    fails++; $display("FAIL sweep_swept r%0d got %h/%h want 0", cnt - 1, rd2_a, rd2_b); end
            end
            tick; cnt++;
        end
        regWrite = 1'b0;
        tests++; if (cnt !== 32) begin fails++; $display("FAIL sweep_busy_len got %0d want 32", cnt); end
        tests++; if (done_a !== 1'b1 || busy_a !== 1'b0 || done_b !== 1'b1) begin
            fails++; $display("FAIL sweep_done got done=%0b busy=%0b want 1/0", done_a, busy_a); end
        tick;
        tests++; if (done_a !== 1'b0) begin fails++; $display("FAIL sweep_done_pulse got %0b want 0", done_a); end
        zero_models();
        for (int i = 0; i < 32; i++) begin
            readReg1 = 5'(i); displayReg = 5'(i); #1;
            tests++; if (rd1_a !== 32'd0 || disp_a !== 32'd0 || rd1_b !== 32'd0) begin
                fails++; $display("FAIL sweep_cleared r%0d got %h/%h/%h want 0", i, rd1_a, disp_a, rd1_b); end
        end
    endtask

    task automatic test_clear_while_busy;
        int cnt, dones;
        clear = 1'b1; tick; clear = 1'b0;
        cnt = 0; dones = 0;
        while (busy_a === 1'b1 && cnt < 40) begin
            clear = (cnt == 10 || cnt == 11);
            if (done_a === 1'b1) dones++;
            tick; cnt++;
        end
        clear = 1'b0;
        tests++; if (cnt !== 32) begin fails++; $display("FAIL reclear_busy_len got %0d want 32", cnt); end
        clear = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (done_a === 1'b1) dones++;
            tick; clear = 1'b0;
        end
        tests++; if (dones !== 1) begin fails++; $display("FAIL reclear_done_count got %0d want 1", dones); end
        tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL clear_in_done got busy=%0b want 0", busy_a); end
    endtask

    task automatic test_clear_with_write;
        int cnt;
        drive_write(5'd20, 32'hA5A5A5A5, 4'hF);
        regWrite = 1'b1; writeReg = 5'd20; writeData = 32'h5A5A5A5A; byteEn = 4'hF; clear = 1'b1;
        tick; regWrite = 1'b0; clear = 1'b0;
        readReg1 = 5'd20; #1;
        tests++; if (busy_a !== 1'b1 || rd1_a !== 32'h5A5A5A5A) begin
            fails++; $display("FAIL clear_write got busy=%0b r20=%h want 1/5a5a5a5a", busy_a, rd1_a); end
        cnt = 0;
        while (busy_a === 1'b1 && cnt < 40) begin tick; cnt++; end
        tick;
        zero_models();
        tests++; if (rd1_a !== 32'd0 || rd1_b !== 32'd0) begin
            fails++; $display("FAIL clear_write_swept got %h/%h want 0", rd1_a, rd1_b); end
    endtask

    task automatic test_reset_mid_sweep;
        for (int i = 1; i <= 10; i++) drive_write(5'(i), $urandom | 32'd1, 4'hF);
        clear = 1'b1; tick; clear = 1'b0;
        for (int k = 0; k < 5; k++) tick;
        tests++; if (busy_a !== 1'b1) begin fails++; $display("FAIL midsweep_busy got %0b want 1", busy_a); end
        #2 reset = 1'b1;
        #1;
        tests++; if (busy_a !== 1'b0 || done_a !== 1'b0 || busy_b !== 1'b0) begin
            fails++; $display("FAIL async_reset got busy=%0b done=%0b want 0/0", busy_a, done_a); end
        zero_models();
        for (int i = 0; i < 32; i++) begin
            readReg1 = 5'(i); #1;
            tests++; if (rd1_a !== 32'd0 || rd1_b !== 32'd0) begin
                fails++; $display("FAIL async_reset_entry r%0d got %h/%h want 0", i, rd1_a, rd1_b); end
        end
        reset = 1'b0;
        tick;
        drive_write(5'd4, 32'h00000011, 4'hF);
        readReg1 = 5'd4; #1;
        tests++; if (rd1_a !== 32'h11 || busy_a !== 1'b0) begin
            fails++; $display("FAIL post_reset_idle got r4=%h busy=%0b want 11/0", rd1_a, busy_a); end
    endtask

    initial begin
        reset = 1'b1; regWrite = 1'b0; clear = 1'b0;
        readReg1 = 5'd0; readReg2 = 5'd0; writeReg = 5'd0; displayReg = 5'd0;
        writeData = 32'd0; byteEn = 4'h0;
        zero_models();
        test_reset();
        test_byte_enable();
        test_zero_reg();
        test_bypass();
        test_sweep();
        test_clear_while_busy();
        test_clear_with_write();
        test_reset_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
